// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button input stage.
package button_defs;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_WAIT_PRESS,
    BTN_PRESSED,
    BTN_WAIT_RELEASE
  } btn_state_t;

  // 10 ms at 100 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Bit positions within the {btnd, btnr, btnu, btnl, btnc} vector.
  localparam int unsigned BTN_C_IDX = 0;
  localparam int unsigned BTN_L_IDX = 1;
  localparam int unsigned BTN_U_IDX = 2;
  localparam int unsigned BTN_R_IDX = 3;
  localparam int unsigned BTN_D_IDX = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with stability counter,
// registered level and single-cycle press pulse.
module debounce_channel
  import button_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 sync1_q, sync2_q;
  btn_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 pulse_q, pulse_d;

  // State register: synchronizer, FSM state, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= BTN_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BTN_IDLE: begin
        if (sync2_q) begin
          state_d = BTN_WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      BTN_WAIT_PRESS: begin
        if (!sync2_q) begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BTN_PRESSED: begin
        if (!sync2_q) begin
          state_d = BTN_WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      BTN_WAIT_RELEASE: begin
        if (sync2_q) begin
          state_d = BTN_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = BTN_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: level follows the accepted state, pulse fires only on entry to PRESSED.
  always_comb begin
    level_d = (state_d == BTN_PRESSED) || (state_d == BTN_WAIT_RELEASE);
    pulse_d = (state_q == BTN_WAIT_PRESS) && (state_d == BTN_PRESSED);
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw push-buttons: one independent debounce channel per button.
module button_conditioner
  import button_defs::*;
#(
  parameter int unsigned NUM_BTNS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse
);

  // One channel per button, no shared state between them.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in[i]),
      .btn_level(btn_level[i]),
      .btn_pulse(btn_pulse[i])
    );
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the lab calculator. Conditions the five raw push-buttons: synchronizes them, debounces them, and produces both a clean level and a single-cycle press pulse for each.
- The calculator's accumulator-load (btnd) and clear (btnu) paths consume the pulses, so each physical press causes exactly one register update.
- Operation-select buttons (btnl, btnc, btnr) consume the debounced levels.

Parameters:
- NUM_BTNS, 5, number of independent button channels. Bit order {btnd, btnr, btnu, btnl, btnc} = [4:0].
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before accepting a level change. 10 ms at 100 MHz. Legal minimum is 2.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), width of each per-channel counter. Derived; not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- btn_in  input  NUM_BTNS  raw, asynchronous button pins
- btn_level  output  NUM_BTNS  debounced button state, registered
- btn_pulse  output  NUM_BTNS  one-cycle strobe on accepted press, registered

Behaviour:
- One clock, clk. rst is asynchronous, active-high, and acts on all flops.
- Reset values: all synchronizer flops 0, every channel FSM in IDLE, all counters 0, btn_level = 0, btn_pulse = 0.
- Synchronizer: per channel, two flops sync1 then sync2. Only sync2 feeds the FSM.
- Per-channel FSM has four states:
  - IDLE: level 0. If sync2 = 1, go to WAIT_PRESS and set cnt = 1. Otherwise stay.
  - WAIT_PRESS: level 0.
    - sync2 = 0: go to IDLE, cnt = 0 (glitch rejected).
    - sync2 = 1 and cnt == DEBOUNCE_CYCLES-1: go to PRESSED, cnt = 0, level <= 1, pulse <= 1.
    - Otherwise cnt++.
  - PRESSED: level 1. If sync2 = 0, go to WAIT_RELEASE and set cnt = 1.
  - WAIT_RELEASE: level 1.
    - sync2 = 1: return to PRESSED, cnt = 0.
    - sync2 = 0 and cnt == DEBOUNCE_CYCLES-1: go to IDLE, cnt = 0, level <= 0.
    - Otherwise cnt++.
- btn_pulse is high for exactly one cycle, on entry to PRESSED only. It is cleared the next cycle. Release produces no pulse.
- Latency, counting the first rising edge that samples btn_in = 1 as edge 0:
  - btn_level and btn_pulse rise after edge DEBOUNCE_CYCLES+1.
  - btn_pulse falls after edge DEBOUNCE_CYCLES+2.
  - Release is symmetric: btn_level falls after edge DEBOUNCE_CYCLES+1, counted from the first edge sampling 0.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Channels are fully independent. Simultaneous presses with identical timing give coincident pulses.
- Reset mid-operation: everything returns to reset values immediately. A button held through reset deassertion is treated as a new press and pulses after edge DEBOUNCE_CYCLES+1, counted from the first post-reset edge.
- Bounce shorter than DEBOUNCE_CYCLES in either direction produces no level change and no pulse.
- A held button yields exactly one pulse. There is no auto-repeat.

Decomposition:
- Package button_defs holds:
  - typedef enum logic [1:0] btn_state_t {BTN_IDLE, BTN_WAIT_PRESS, BTN_PRESSED, BTN_WAIT_RELEASE}
  - localparam DEFAULT_DEBOUNCE_CYCLES = 1_000_000
  - localparams for the bit index of each named button
- Sub-module debounce_channel holds one channel: the synchronizer, FSM and counter, with 1-bit in/level/pulse.
- button_conditioner instantiates NUM_BTNS copies of debounce_channel via a generate loop.

Test Plan (DEBOUNCE_CYCLES = 4, NUM_BTNS = 5):
- Clean press: btn_in[4] 0→1 and held, first sampled at edge 0 -> btn_level[4] and btn_pulse[4] rise after edge 5; btn_pulse[4] returns to 0 after edge 6; btn_level stays 1; no second pulse over 50 cycles.
- Bounce reject: btn_in[0] toggles 1,1,0,1,0 on consecutive edges, then 0 -> btn_level[0] = 0 and btn_pulse[0] = 0 throughout.
- Release with bounce: held button, then pattern 0,1,0,0,0,0 -> btn_level stays 1 through the glitch and falls 4 stable-low cycles after the final 0 run begins (+2 sync); no pulse on release.
- Simultaneous: btn_in = 5'b10101 asserted on the same edge -> btn_pulse = 5'b10101 for exactly one cycle after edge 5; other bits stay 0.
- Reset mid-operation: assert rst in WAIT_PRESS (edge 3), hold the button, deassert rst -> outputs 0 immediately on rst; the pulse occurs after edge 5 counted from the first post-reset edge.
- Repeat presses: press held 10 cycles, release held 10 cycles, repeated 3 times -> exactly 3 pulses, each exactly 1 cycle wide.
